// File: rtl/output_collector_pkg.sv
// ============================================================================
// Module   : output_collector_pkg
// Brief    : Shared record type, FSM state enum and final-element helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package output_collector_pkg;

    localparam int c_COORD_W    = 32;
    // Widest DATA_WIDTH supported; narrower data is zero-extended in the record.
    localparam int c_MAX_DATA_W = 64;

    typedef logic [c_COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [c_MAX_DATA_W-1:0] data;
        coord_t                  x;
        coord_t                  y;
        coord_t                  ch;
    } out_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } oc_state_t;

    function automatic logic is_final(input out_rec_t rec, input coord_t last_x,
                                      input coord_t last_y, input coord_t last_ch);
        return (rec.x == last_x) && (rec.y == last_y) && (rec.ch == last_ch);
    endfunction

endpackage

`default_nettype wire

// File: rtl/output_collector_if.sv
// ============================================================================
// Module   : output_collector_if
// Brief    : Input stream and buffered output stream of the output collector.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface output_collector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [31:0]           in_x;
    logic [31:0]           in_y;
    logic [31:0]           in_ch;
    logic                  stall_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [31:0]           out_x;
    logic [31:0]           out_y;
    logic [31:0]           out_ch;
    logic                  out_last;
    logic                  frame_done;
    logic                  overflow_err;
    logic [c_CNT_W-1:0]    fill_count;

    modport master (
        output in_valid, in_data, in_x, in_y, in_ch, out_ready,
        input  stall_out, out_valid, out_data, out_x, out_y, out_ch,
               out_last, frame_done, overflow_err, fill_count
    );

    modport slave (
        input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
        output stall_out, out_valid, out_data, out_x, out_y, out_ch,
               out_last, frame_done, overflow_err, fill_count
    );

endinterface

`default_nettype wire

// File: rtl/output_collector_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Register-based FIFO; the head holds the last popped word when empty.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [c_AW-1:0]  wptr_q;
    logic [c_AW-1:0]  rptr_q;
    logic [c_CW-1:0]  count_q;
    logic [c_CW-1:0]  count_d;
    logic [WIDTH-1:0] last_q;
    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == c_CW'(DEPTH));
    assign w_pop_ok  = pop_i && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = push_i && (!w_full || w_pop_ok);

    always_comb begin
        count_d = count_q;
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            count_q <= count_d;
            if (w_push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop_ok) begin
                rptr_q <= rptr_q + 1'b1;
                last_q <= mem_q[rptr_q];
            end
        end
    end

    assign rdata_o = w_empty ? last_q : mem_q[rptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/output_collector.sv
// ============================================================================
// Module   : output_collector
// Brief    : Buffers controller outputs per frame and flags the final element.
// Revision : 1.0
// ============================================================================
`default_nettype none

module output_collector
    import output_collector_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 4,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              start,
    output_collector_if.slave bus
);
    localparam int     c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam coord_t c_LAST_X  = coord_t'(FEATURE_MAP_WIDTH - 1);
    localparam coord_t c_LAST_Y  = coord_t'(FEATURE_MAP_HEIGHT - 1);
    localparam coord_t c_LAST_CH = coord_t'(OUTPUT_NB_CHANNELS - 1);

    oc_state_t          state_q, state_d;
    logic               overflow_q, overflow_d;
    logic               frame_done_q, frame_done_d;
    out_rec_t           w_in_rec;
    out_rec_t           w_head;
    logic [c_CNT_W-1:0] w_count;
    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push_ok;
    logic               w_in_last;
    logic               w_head_last;
    logic               w_unused_data;

    always_comb begin
        w_in_rec                       = '0;
        w_in_rec.data[DATA_WIDTH-1:0]  = bus.in_data;
        w_in_rec.x                     = bus.in_x;
        w_in_rec.y                     = bus.in_y;
        w_in_rec.ch                    = bus.in_ch;
    end

    assign w_valid     = (w_count != '0);
    assign w_full      = (w_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop       = w_valid && bus.out_ready;
    assign w_push_req  = (state_q == ST_RUN) && bus.in_valid;
    assign w_push_ok   = w_push_req && (!w_full || w_pop);
    assign w_in_last   = is_final(w_in_rec, c_LAST_X, c_LAST_Y, c_LAST_CH);
    assign w_head_last = is_final(w_head, c_LAST_X, c_LAST_Y, c_LAST_CH);

    sync_fifo #(
        .WIDTH ($bits(out_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst_in),
        .push_i  (w_push_ok),
        .pop_i   (w_pop),
        .wdata_i (w_in_rec),
        .rdata_o (w_head),
        .count_o (w_count)
    );

    always_comb begin
        state_d      = state_q;
        overflow_d   = overflow_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    overflow_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_push_req && !w_push_ok) begin
                    overflow_d = 1'b1;
                end
                if (w_push_ok && w_in_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The frame is closed: any further input is lost.
                if (bus.in_valid) begin
                    overflow_d = 1'b1;
                end
                if (w_pop && w_head_last) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign w_unused_data    = ^w_head.data;

    assign bus.out_valid    = w_valid;
    assign bus.fill_count   = w_count;
    assign bus.stall_out    = (w_count >= c_CNT_W'(FIFO_DEPTH - 1));
    assign bus.out_data     = w_head.data[DATA_WIDTH-1:0];
    assign bus.out_x        = w_head.x;
    assign bus.out_y        = w_head.y;
    assign bus.out_ch       = w_head.ch;
    assign bus.out_last     = w_valid && w_head_last;
    assign bus.frame_done   = frame_done_q;
    assign bus.overflow_err = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_output_collector.sv
// ============================================================================
// Module   : tb_output_collector
// Brief    : Directed and randomized checks of output_collector against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_output_collector;
    localparam int DW = 32, DEPTH = 4, FW = 2, FH = 2, NC = 1;

    typedef struct {
        logic [31:0] data;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } rec_t;

    logic clk = 1'b0;
    logic rst_in = 1'b0;
    logic start = 1'b0;

    output_collector_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    output_collector #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FEATURE_MAP_WIDTH(FW),
        .FEATURE_MAP_HEIGHT(FH), .OUTPUT_NB_CHANNELS(NC)
    ) dut (
        .clk(clk), .rst_in(rst_in), .start(start), .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    rec_t m_q[$];
    rec_t m_last;
    int   m_mode;  // 0 idle, 1 collecting, 2 waiting for the final element to leave
    bit   m_ovf;
    bit   m_fd;

    function automatic bit final_coord(rec_t r);
        return (r.x == FW - 1) && (r.y == FH - 1) && (r.ch == NC - 1);
    endfunction

    task automatic model_step();
        rec_t r;
        bit   popped_final;
        popped_final = 1'b0;
        m_fd = 1'b0;
        if (rst_in) begin
            m_q.delete();
            m_mode = 0;
            m_ovf  = 1'b0;
            m_last = '{default: 0};
        end else begin
            if (m_q.size() != 0 && bus.out_ready) begin
                m_last = m_q.pop_front();
                popped_final = final_coord(m_last);
            end
            r.data = bus.in_data; r.x = bus.in_x; r.y = bus.in_y; r.ch = bus.in_ch;
            if (m_mode == 0) begin
                if (start) begin m_mode = 1; m_ovf = 1'b0; end
            end else if (m_mode == 1) begin
                if (bus.in_valid) begin
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back(r);
                        if (final_coord(r)) m_mode = 2;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end else begin
                if (bus.in_valid) m_ovf = 1'b1;
                if (popped_final) begin m_mode = 0; m_fd = 1'b1; end
            end
        end
    endtask

    task automatic drive(bit s, bit v, logic [31:0] d, logic [31:0] x, logic [31:0] y,
                         logic [31:0] ch, bit rdy);
        start = s; bus.in_valid = v; bus.in_data = d;
        bus.in_x = x; bus.in_y = y; bus.in_ch = ch; bus.out_ready = rdy;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        rst_in = 1'b0;
    endtask

    task automatic do_start(bit rdy);
        drive(1, 0, 0, 0, 0, 0, rdy);
        cycle();
    endtask

    task automatic test_reset();
        rst_in = 1'b1; drive(1, 1, 32'hDEAD_BEEF, 0, 0, 0, 1);
        cycle();
        rst_in = 1'b0; drive(0, 0, 0, 0, 0, 0, 0);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.fill_count !== 3'd0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", bus.fill_count); end
        n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_err); end
        n_vec++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
        n_vec++; if (bus.stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall_out); end
        n_vec++; if (bus.out_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %0h want 0", bus.out_data); end
        drive(0, 1, 32'h55, 0, 0, 0, 0);
        cycle();
        n_vec++; if (bus.fill_count !== 3'd0) begin n_err++; $display("FAIL reset_start_ignored: got %0d want 0", bus.fill_count); end
    endtask

    task automatic test_basic();
        do_reset();
        do_start(1);
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_prepush: got %b want 0", bus.out_valid); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'(10 * (i + 1)), 32'(i % 2), 32'(i / 2), 0, 1);
            cycle();
            n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid%0d: got %b want 1", i, bus.out_valid); end
            n_vec++; if (bus.out_data !== 32'(10 * (i + 1))) begin n_err++; $display("FAIL basic_data%0d: got %0d want %0d", i, bus.out_data, 10 * (i + 1)); end
            n_vec++; if (bus.fill_count !== 3'd1) begin n_err++; $display("FAIL basic_fill%0d: got %0d want 1", i, bus.fill_count); end
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_data !== 32'd30) begin n_err++; $display("FAIL basic_hold: got %0d want 30", bus.out_data); end
    endtask

    task automatic test_full();
        do_reset();
        do_start(0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'(100 + i), 32'(i % 2), 0, 0, 0);
            cycle();
            if (i == 1) begin
                n_vec++; if (bus.stall_out !== 1'b0) begin n_err++; $display("FAIL full_stall2: got %b want 0", bus.stall_out); end
            end
            if (i == 2) begin
                n_vec++; if (bus.stall_out !== 1'b1) begin n_err++; $display("FAIL full_stall3: got %b want 1", bus.stall_out); end
            end
        end
        n_vec++; if (bus.fill_count !== 3'd4) begin n_err++; $display("FAIL full_fill: got %0d want 4", bus.fill_count); end
        drive(0, 1, 32'd104, 0, 0, 0, 0);
        cycle();
        n_vec++; if (bus.overflow_err !== 1'b1) begin n_err++; $display("FAIL full_ovf: got %b want 1", bus.overflow_err); end
        n_vec++; if (bus.fill_count !== 3'd4) begin n_err++; $display("FAIL full_fill5: got %0d want 4", bus.fill_count); end
        n_vec++; if (bus.out_data !== 32'd100) begin n_err++; $display("FAIL full_head: got %0d want 100", bus.out_data); end
    endtask

    task automatic test_wrap();
        logic [31:0] d[6];
        logic [31:0] got[$];
        for (int i = 0; i < 6; i++) d[i] = $urandom;
        do_reset();
        do_start(0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, d[i], 0, 0, 0, 0);
            cycle();
        end
        for (int i = 4; i < 6; i++) begin
            drive(0, 1, d[i], 0, 0, 0, 1);
            if (bus.out_valid) got.push_back(bus.out_data);
            cycle();
            n_vec++; if (bus.fill_count !== 3'd4) begin n_err++; $display("FAIL wrap_fill%0d: got %0d want 4", i, bus.fill_count); end
            n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL wrap_ovf%0d: got %b want 0", i, bus.overflow_err); end
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid) got.push_back(bus.out_data);
            cycle();
        end
        n_vec++; if (got.size() != 6) begin n_err++; $display("FAIL wrap_count: got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_vec++; if (got[i] !== d[i]) begin n_err++; $display("FAIL wrap_order%0d: got %0h want %0h", i, got[i], d[i]); end
        end
    endtask

    task automatic test_frame();
        int fd_cnt;
        int popped;
        bit pop_final_prev;
        fd_cnt = 0; popped = 0; pop_final_prev = 1'b0;
        do_reset();
        do_start(0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'(200 + i), 32'(i % 2), 32'(i / 2), 0, 0);
            cycle();
        end
        n_vec++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL frame_last_head0: got %b want 0", bus.out_last); end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            if (popped < 4) begin
                n_vec++; if (bus.out_last !== (popped == 3)) begin n_err++; $display("FAIL frame_last%0d: got %b want %b", popped, bus.out_last, popped == 3); end
            end
            pop_final_prev = (popped == 3);
            if (popped < 4) popped++;
            cycle();
            if (bus.frame_done === 1'b1) fd_cnt++;
            n_vec++; if (bus.frame_done !== pop_final_prev) begin n_err++; $display("FAIL frame_done_t%0d: got %b want %b", k, bus.frame_done, pop_final_prev); end
            pop_final_prev = 1'b0;
        end
        n_vec++; if (fd_cnt != 1) begin n_err++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
        drive(0, 1, 32'd7, 0, 0, 0, 0);
        cycle();
        n_vec++; if (bus.fill_count !== 3'd0) begin n_err++; $display("FAIL frame_idle_push: got %0d want 0", bus.fill_count); end
        n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL frame_idle_ovf: got %b want 0", bus.overflow_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_start(0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'(300 + i), 0, 0, 0, 0);
            cycle();
        end
        rst_in = 1'b1; drive(1, 1, 32'd399, 0, 0, 0, 1);
        cycle();
        rst_in = 1'b0;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL rstmid_fd: got %b want 0", bus.frame_done); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 32'(500 + i), 0, 0, 0, 0);
            cycle();
            n_vec++; if (bus.fill_count !== 3'd0) begin n_err++; $display("FAIL rstmid_idle_fill%0d: got %0d want 0", i, bus.fill_count); end
            n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL rstmid_idle_ovf%0d: got %b want 0", i, bus.overflow_err); end
        end
    endtask

    task automatic test_drain_overflow();
        do_reset();
        do_start(0);
        drive(0, 1, 32'd42, FW - 1, FH - 1, NC - 1, 0);
        cycle();
        n_vec++; if (bus.out_last !== 1'b1) begin n_err++; $display("FAIL drain_last: got %b want 1", bus.out_last); end
        drive(1, 1, 32'd43, 0, 0, 0, 0);
        cycle();
        n_vec++; if (bus.overflow_err !== 1'b1) begin n_err++; $display("FAIL drain_ovf: got %b want 1", bus.overflow_err); end
        n_vec++; if (bus.fill_count !== 3'd1) begin n_err++; $display("FAIL drain_fill: got %0d want 1", bus.fill_count); end
        drive(0, 0, 0, 0, 0, 0, 1);
        cycle();
        n_vec++; if (bus.frame_done !== 1'b1) begin n_err++; $display("FAIL drain_fd: got %b want 1", bus.frame_done); end
        n_vec++; if (bus.overflow_err !== 1'b1) begin n_err++; $display("FAIL drain_ovf_sticky: got %b want 1", bus.overflow_err); end
        do_start(0);
        n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL drain_start_clear: got %b want 0", bus.overflow_err); end
    endtask

    task automatic test_random();
        logic [31:0] exp_data;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_in = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
            cycle();
            exp_data = (m_q.size() != 0) ? m_q[0].data : m_last.data;
            n_vec++; if (bus.fill_count !== 3'(m_q.size())) begin n_err++; $display("FAIL rnd_fill@%0d: got %0d want %0d", i, bus.fill_count, m_q.size()); end
            n_vec++; if (bus.out_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", i, bus.out_valid, m_q.size() != 0); end
            n_vec++; if (bus.stall_out !== (m_q.size() >= DEPTH - 1)) begin n_err++; $display("FAIL rnd_stall@%0d: got %b want %b", i, bus.stall_out, m_q.size() >= DEPTH - 1); end
            n_vec++; if (bus.out_data !== exp_data) begin n_err++; $display("FAIL rnd_data@%0d: got %0h want %0h", i, bus.out_data, exp_data); end
            n_vec++; if (bus.out_last !== (m_q.size() != 0 && final_coord(m_q[0]))) begin n_err++; $display("FAIL rnd_last@%0d: got %b", i, bus.out_last); end
            n_vec++; if (bus.overflow_err !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, bus.overflow_err, m_ovf); end
            n_vec++; if (bus.frame_done !== m_fd) begin n_err++; $display("FAIL rnd_fd@%0d: got %b want %b", i, bus.frame_done, m_fd); end
        end
        rst_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_mode = 0; m_ovf = 1'b0; m_fd = 1'b0; m_last = '{default: 0};
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_frame();
        test_reset_mid();
        test_drain_overflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
